// File: rtl/npc_multicycle_core_if.sv
// Instruction-fetch bus between the core (master) and the memory/bus adapter (slave).
// The request is held until ready; a response is accepted only while the core waits for it.
interface npc_multicycle_core_if #(
  parameter int XLEN = 32
);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_addr;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rsp_inst;

  modport master (
    output ifu_req_valid,
    output ifu_addr,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_addr,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_inst
  );
endinterface

// File: rtl/npc_multicycle_core.sv
// Multi-cycle RV32I/E subset core: FETCH -> WAIT -> EXEC, 3 cycles per instruction at best.
// Fetch stalls on ifu_req_ready/ifu_rsp_valid; EBREAK or an illegal instruction halts until reset.
module npc_multicycle_core #(
  parameter int              XLEN     = 32,
  parameter int              NR_GPR   = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  npc_multicycle_core_if.master ifu,
  output logic [XLEN-1:0]      pc,
  output logic                 commit_valid,
  output logic [XLEN-1:0]      commit_pc,
  output logic [31:0]          commit_inst,
  output logic                 halt,
  output logic                 halt_illegal,
  output logic [XLEN-1:0]      halt_code
);
  localparam int AW = (NR_GPR > 1) ? $clog2(NR_GPR) : 1;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_e;

  state_e          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_gpr [NR_GPR];
  logic [XLEN-1:0] r_cpc;
  logic [31:0]     r_cinst;
  logic            r_halt, r_halt_ill;
  logic [XLEN-1:0] r_halt_code;

  logic [6:0]      w_opc, w_f7;
  logic [4:0]      w_rd, w_rs1, w_rs2, w_shamt;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_pc4;
  logic            w_rd_ok, w_rs1_ok, w_rs2_ok;
  logic            w_legal, w_wen, w_ebreak, w_use_rs1, w_use_rs2;
  logic [XLEN-1:0] w_wdat, w_target;
  logic            w_commit, w_do_halt, w_gpr_we;

  assign w_opc   = r_ir[6:0];
  assign w_rd    = r_ir[11:7];
  assign w_f3    = r_ir[14:12];
  assign w_rs1   = r_ir[19:15];
  assign w_rs2   = r_ir[24:20];
  assign w_shamt = r_ir[24:20];
  assign w_f7    = r_ir[31:25];

  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));

  assign w_rd_ok  = ({1'b0, w_rd}  < 6'(NR_GPR));
  assign w_rs1_ok = ({1'b0, w_rs1} < 6'(NR_GPR));
  assign w_rs2_ok = ({1'b0, w_rs2} < 6'(NR_GPR));

  // x0 reads as zero; out-of-range indices are illegal anyway, so their value is irrelevant
  assign w_rs1_val = (w_rs1 == 5'd0 || !w_rs1_ok) ? '0 : r_gpr[w_rs1[AW-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0 || !w_rs2_ok) ? '0 : r_gpr[w_rs2[AW-1:0]];
  assign w_pc4     = r_pc + XLEN'(4);

  always_comb begin
    w_legal   = 1'b0;
    w_wen     = 1'b0;
    w_ebreak  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_wdat    = '0;
    w_target  = w_pc4;
    case (w_opc)
      7'b0010011: begin
        w_legal   = 1'b1;
        w_wen     = 1'b1;
        w_use_rs1 = 1'b1;
        case (w_f3)
          3'b000:  w_wdat = w_rs1_val + w_imm_i;
          3'b010:  w_wdat = XLEN'($signed(w_rs1_val) < $signed(w_imm_i));
          3'b011:  w_wdat = XLEN'(w_rs1_val < w_imm_i);
          3'b100:  w_wdat = w_rs1_val ^ w_imm_i;
          3'b110:  w_wdat = w_rs1_val | w_imm_i;
          3'b111:  w_wdat = w_rs1_val & w_imm_i;
          3'b001: begin
            w_wdat  = w_rs1_val << w_shamt;
            w_legal = (w_f7 == 7'b0000000);
          end
          default: begin
            if (w_f7 == 7'b0000000)      w_wdat = w_rs1_val >> w_shamt;
            else if (w_f7 == 7'b0100000) w_wdat = XLEN'($signed(w_rs1_val) >>> w_shamt);
            else                         w_legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        w_wen     = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        if (w_f3 == 3'b000 && w_f7 == 7'b0000000) begin
          w_legal = 1'b1;
          w_wdat  = w_rs1_val + w_rs2_val;
        end else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) begin
          w_legal = 1'b1;
          w_wdat  = w_rs1_val - w_rs2_val;
        end
      end
      7'b0110111: begin
        w_legal = 1'b1;
        w_wen   = 1'b1;
        w_wdat  = w_imm_u;
      end
      7'b0010111: begin
        w_legal = 1'b1;
        w_wen   = 1'b1;
        w_wdat  = r_pc + w_imm_u;
      end
      7'b1101111: begin
        w_legal  = 1'b1;
        w_wen    = 1'b1;
        w_wdat   = w_pc4;
        w_target = r_pc + w_imm_j;
      end
      7'b1100111: begin
        w_legal   = (w_f3 == 3'b000);
        w_wen     = 1'b1;
        w_use_rs1 = 1'b1;
        w_wdat    = w_pc4;
        w_target  = (w_rs1_val + w_imm_i) & ~XLEN'(1);
      end
      7'b1110011: begin
        w_legal  = (r_ir == 32'h0010_0073);
        w_ebreak = (r_ir == 32'h0010_0073);
      end
      default: ;
    endcase
    // register fields beyond the implemented file (RV32E) make the instruction illegal
    if ((w_wen && !w_rd_ok) || (w_use_rs1 && !w_rs1_ok) || (w_use_rs2 && !w_rs2_ok))
      w_legal = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_commit    = 1'b0;
    w_do_halt   = 1'b0;
    w_gpr_we    = 1'b0;
    case (r_state)
      S_FETCH: if (ifu.ifu_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (ifu.ifu_rsp_valid) w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_commit = w_legal;
        w_gpr_we = w_legal && w_wen && (w_rd != 5'd0);
        if (!w_legal || w_ebreak) begin
          w_do_halt   = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_cpc       <= '0;
      r_cinst     <= '0;
      r_halt      <= 1'b0;
      r_halt_ill  <= 1'b0;
      r_halt_code <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == S_WAIT && ifu.ifu_rsp_valid) r_ir <= ifu.ifu_rsp_inst;
      if (w_commit) begin
        r_cpc   <= r_pc;
        r_cinst <= r_ir;
      end
      if (w_do_halt) begin
        r_halt      <= 1'b1;
        r_halt_ill  <= !w_legal;
        r_halt_code <= r_gpr[10];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR_GPR; i++) r_gpr[i] <= '0;
    end else if (w_gpr_we) begin
      r_gpr[w_rd[AW-1:0]] <= w_wdat;
    end
  end

  assign ifu.ifu_req_valid = (r_state == S_FETCH);
  assign ifu.ifu_addr      = r_pc;
  assign pc                = r_pc;
  // commit fields track the retiring instruction in EXEC and hold afterwards
  assign commit_valid      = w_commit;
  assign commit_pc         = w_commit ? r_pc : r_cpc;
  assign commit_inst       = w_commit ? r_ir : r_cinst;
  assign halt              = r_halt;
  assign halt_illegal      = r_halt_ill;
  assign halt_code         = r_halt_code;
endmodule

// File: doc/npc_multicycle_core.md
Name: npc_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle NPC core.
- Fetches each instruction over a valid/ready request plus response handshake, then decodes and executes it and writes it back through an internal register file.
- Supports RV32I/RV32E through a parameter.
- Reports each retired instruction on a commit port, and reports halt on EBREAK or on an illegal instruction.
- Sits between the instruction memory/bus adapter and the simulation harness.

Parameters:
- XLEN, 32, datapath and PC width. Only 32 is supported; width-generic coding is still required.
- NR_GPR, 32, number of architectural registers: 32 (RV32I) or 16 (RV32E).
- RESET_PC, 32'h8000_0000, PC value loaded at reset.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- ifu_req_valid  output  1  fetch request valid.
- ifu_req_ready  input  1  fetch request accepted.
- ifu_addr  output  XLEN  fetch address, equal to pc.
- ifu_rsp_valid  input  1  fetch response valid.
- ifu_rsp_inst  input  32  fetched instruction word.
- pc  output  XLEN  current PC.
- commit_valid  output  1  one-cycle pulse per retired instruction.
- commit_pc  output  XLEN  PC of the retired instruction.
- commit_inst  output  32  retired instruction word.
- halt  output  1  core halted (sticky).
- halt_illegal  output  1  halt was caused by an illegal instruction (sticky).
- halt_code  output  XLEN  value of x10 (a0) when the halt occurred.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, pc=RESET_PC.
  - All GPRs = 0.
  - All other outputs = 0.
- States:
  - FETCH: ifu_req_valid=1, ifu_addr=pc. Both are held stable until ifu_req_ready=1, then go to WAIT.
  - WAIT: when ifu_rsp_valid=1, latch ifu_rsp_inst into the internal IR and go to EXEC. ifu_rsp_valid in any other state is ignored.
  - EXEC: one cycle that decodes, executes, writes rd, updates pc and pulses commit_valid with commit_pc/commit_inst. Next state is FETCH, or HALT.
  - HALT: absorbing. No requests are issued, no state changes occur. Only reset leaves HALT.
- Throughput: with ready and response both immediate, one instruction retires every 3 cycles (FETCH, WAIT, EXEC).
- Supported instructions:
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB.
  - LUI, AUIPC, JAL, JALR, EBREAK.
- Anything else is illegal, including SLLI/SRLI/SRAI with a bad funct7 and any register field >= NR_GPR.
- Arithmetic rules:
  - All arithmetic is modulo 2^XLEN.
  - Immediates are sign-extended per format (I/U/J).
  - The shift amount is inst[24:20].
  - SLTIU compares unsigned, after sign extension of the immediate.
- Control flow:
  - JAL: rd=pc+4, pc=pc+imm_J.
  - JALR: rd=pc+4, pc=(rs1+imm_I) & ~1. rs1 is read before rd is written, so rd==rs1 works.
  - All other non-halting instructions: pc=pc+4.
- x0: writes are discarded and reads return 0.
- EBREAK:
  - commit_valid pulses.
  - halt=1, halt_illegal=0, halt_code=x10.
  - pc is unchanged. Next state is HALT.
- Illegal instruction:
  - No commit pulse, no GPR write.
  - halt=1, halt_illegal=1, halt_code=x10.
  - pc is unchanged. Next state is HALT.
- Misaligned target (bit 1 of the new pc set): no trap; the pc is taken as is.
- Reset during WAIT: an in-flight response is dropped. The environment must not deliver a response after reset.
- commit_pc/commit_inst: valid only while commit_valid=1; they hold their last values otherwise.

Test Plan:
- Reset, then ifu_req_ready=1 and a response one cycle later, fetching ADDI x1,x0,5 (0x00500093) -> first ifu_addr=0x8000_0000; commit in cycle 3 with commit_pc=0x8000_0000; x1=5; pc=0x8000_0004.
- Stall: hold ifu_req_ready=0 for 4 cycles, then delay the response by 3 cycles -> ifu_addr stable throughout, no commit, ifu_req_valid stays 1 until ready, retire occurs after the delays.
- Sequence ADDI x10,x0,-1; SRAI x11,x10,4; SRLI x12,x10,28; SLTIU x13,x0,-1 -> x11=0xFFFF_FFFF, x12=0xF, x13=1.
- JAL x1,+8 at 0x8000_0000, then JALR x0,0(x1) -> pc=0x8000_0008, x1=0x8000_0004, then pc=0x8000_0004; a write to x0 leaves x0=0.
- Set x10=42, then EBREAK (0x00100073) -> commit pulse, halt=1, halt_illegal=0, halt_code=42, ifu_req_valid stays 0 afterwards.
- NR_GPR=16: ADDI x16,x0,1 -> no commit, halt=1, halt_illegal=1. Word 0x00000000 under NR_GPR=32 -> halt_illegal=1. Asserting rst mid-WAIT -> pc=0x8000_0000, halt=0.
